// File: rtl/pixel_clip_buffer_pkg.sv
// Shared types and constants for the pixel clip buffer.
package pixel_clip_buffer_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_e;

  // Saturating increment for the 16-bit statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pixel_clip_buffer_if.sv
// Pixel bus: x/y/colour with plot (valid) and ready handshake.
interface pixel_clip_buffer_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       ready;

  modport master (output x, y, colour, plot, input ready);
  modport slave  (input x, y, colour, plot, output ready);
endinterface

// File: rtl/pixel_clip_buffer_sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is always visible on rdata_o.
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full blocks push even when a pop happens the same cycle (no pass-through).
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state for pointers and occupancy; DEPTH is a power of 2 so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pixel_clip_buffer.sv
// Drops off-screen and back-to-back duplicate pixels, buffers the rest,
// and holds the drawer's done until the buffer has drained to the adapter.
module pixel_clip_buffer
  import pixel_clip_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int X_MAX = SCREEN_W,
  parameter int Y_MAX = SCREEN_H
) (
  input  logic                       clk,
  input  logic                       rst,
  pixel_clip_buffer_if.slave         in_bus,
  pixel_clip_buffer_if.master        out_bus,
  input  logic                       in_done,
  output logic                       out_done,
  output logic [15:0]                clip_count,
  output logic [15:0]                dup_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [8:0] XLIM = 9'(X_MAX);
  localparam logic [7:0] YLIM = 8'(Y_MAX);

  pixel_t        in_pix, head_pix;
  pixel_t        last_q, last_d;
  logic          last_vld_q, last_vld_d;
  logic [15:0]   clip_cnt_q, clip_cnt_d;
  logic [15:0]   dup_cnt_q, dup_cnt_d;
  drain_state_e  state_q, state_d;
  logic          clr_last;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          accept, is_clip, is_dup, push, pop;

  assign in_pix = {in_bus.x, in_bus.y, in_bus.colour};

  assign accept  = in_bus.plot && !fifo_full;
  assign is_clip = ({1'b0, in_pix.x} >= XLIM) || ({1'b0, in_pix.y} >= YLIM);
  assign is_dup  = last_vld_q && (in_pix == last_q);
  assign push    = accept && !is_clip && !is_dup;
  assign pop     = !fifo_empty && out_bus.ready;

  assign in_bus.ready   = !fifo_full;
  assign out_bus.plot   = !fifo_empty;
  assign out_bus.x      = head_pix.x;
  assign out_bus.y      = head_pix.y;
  assign out_bus.colour = head_pix.colour;
  assign out_done       = (state_q == DONE);
  assign clip_count     = clip_cnt_q;
  assign dup_count      = dup_cnt_q;

  sync_fifo #(.WIDTH($bits(pixel_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (in_pix),
    .pop_i   (pop),
    .rdata_o (head_pix),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Drain FSM next state: wait for done, then for the buffer to empty with nothing arriving.
  always_comb begin
    state_d  = state_q;
    clr_last = 1'b0;
    case (state_q)
      IDLE: if (in_done) begin
        state_d  = DRAIN;
        clr_last = 1'b1;
      end
      DRAIN: begin
        if (!in_done)                             state_d = IDLE;
        else if ((fifo_count == '0) && !push)     state_d = DONE;
      end
      DONE: if (!in_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Duplicate tracker and statistics next state; a clip never updates the tracked pixel.
  always_comb begin
    last_d     = push ? in_pix : last_q;
    last_vld_d = clr_last ? 1'b0 : (push ? 1'b1 : last_vld_q);
    clip_cnt_d = (accept && is_clip) ? sat_inc(clip_cnt_q) : clip_cnt_q;
    dup_cnt_d  = (accept && !is_clip && is_dup) ? sat_inc(dup_cnt_q) : dup_cnt_q;
  end

  // State, tracker and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      clip_cnt_q <= '0;
      dup_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      clip_cnt_q <= clip_cnt_d;
      dup_cnt_q  <= dup_cnt_d;
    end
  end

endmodule

// File: tb/tb_pixel_clip_buffer.sv
// Bench for pixel_clip_buffer: vector table, scoreboard of expected adapter pixels,
// hand sequences for back-pressure, drain/done and a full circle.
module tb_pixel_clip_buffer;
  import pixel_clip_buffer_pkg::*;

  localparam int DEPTH = 16;

  typedef enum int {K_PUSH, K_CLIP, K_DUP} kind_e;
  typedef struct {
    pixel_t pix;
    kind_e  kind;
    int     exp_clip;
    int     exp_dup;
  } vec_t;
  typedef struct {
    int x;
    int y;
  } pt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_done = 1'b0;
  logic        out_done;
  logic [15:0] clip_count, dup_count;

  pixel_clip_buffer_if in_if();
  pixel_clip_buffer_if out_if();

  pixel_clip_buffer #(.DEPTH(DEPTH), .X_MAX(160), .Y_MAX(120)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_bus     (in_if),
    .out_bus    (out_if),
    .in_done    (in_done),
    .out_done   (out_done),
    .clip_count (clip_count),
    .dup_count  (dup_count)
  );

  always #5 clk = ~clk;

  int     n_chk = 0;
  int     n_err = 0;
  int     n_pop = 0;
  pixel_t sb[$];
  pixel_t exp_p;
  bit     collect = 1'b0;
  bit     got[int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard check of every pixel the adapter takes.
  always @(negedge clk) begin
    if (!rst && out_if.plot === 1'b1 && out_if.ready === 1'b1) begin
      n_pop++;
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_pop: got (%0d,%0d,%0d), expected no output",
                 out_if.x, out_if.y, out_if.colour);
      end else begin
        exp_p = sb.pop_front();
        chk("pop_pixel", 32'({out_if.x, out_if.y, out_if.colour}), 32'(exp_p));
      end
      if (collect) got[int'({out_if.x, out_if.y})] = 1'b1;
    end
  end

  // Present a pixel until accepted; called and returns at posedge+1.
  task automatic send(input pixel_t p, input kind_e k);
    bit ok;
    ok = 1'b0;
    in_if.x      = p.x;
    in_if.y      = p.y;
    in_if.colour = p.colour;
    in_if.plot   = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (in_if.ready === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      if (k == K_PUSH) sb.push_back(p);
      tick();
    end else begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: got no acceptance, expected in_ready within 300 cycles");
    end
    in_if.plot = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
    chk("drain_empty_sb", 32'(sb.size()), 32'd0);
    tick();
    chk("drain_out_plot", 32'(out_if.plot), 32'd0);
  endtask

  function automatic pixel_t mk(input int x, input int y, input int c);
    pixel_t p;
    p.x = 8'(x);
    p.y = 7'(y);
    p.colour = 3'(c);
    return p;
  endfunction

  function automatic vec_t mv(input int x, input int y, input int c, input kind_e k,
                              input int ec, input int ed);
    vec_t v;
    v.pix = mk(x, y, c);
    v.kind = k;
    v.exp_clip = ec;
    v.exp_dup = ed;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   tbl[16];
    int     pops0, npush, clip0, rises;
    bit     ref_set[int];
    pt_t    pts[$];
    pixel_t p;
    kind_e  k;
    int     ox, oy, crit, m_clip, m_dup, missing, offscr;
    pixel_t m_last;
    bit     m_lv, gen_done;
    logic   prev_done;

    tbl[0]  = mv(160, 10, 1, K_CLIP, 1, 0);
    tbl[1]  = mv(10, 120, 1, K_CLIP, 2, 0);
    tbl[2]  = mv(255, 127, 7, K_CLIP, 3, 0);
    tbl[3]  = mv(159, 119, 5, K_PUSH, 3, 0);
    tbl[4]  = mv(159, 119, 5, K_DUP, 3, 1);
    tbl[5]  = mv(100, 50, 2, K_PUSH, 3, 1);
    tbl[6]  = mv(100, 50, 2, K_DUP, 3, 2);
    tbl[7]  = mv(100, 50, 3, K_PUSH, 3, 2);
    tbl[8]  = mv(100, 50, 2, K_PUSH, 3, 2);
    tbl[9]  = mv(101, 50, 2, K_PUSH, 3, 2);
    tbl[10] = mv(100, 50, 2, K_PUSH, 3, 2);
    tbl[11] = mv(200, 50, 2, K_CLIP, 4, 2);
    tbl[12] = mv(100, 50, 2, K_DUP, 4, 3);
    tbl[13] = mv(0, 0, 0, K_PUSH, 4, 3);
    tbl[14] = mv(159, 120, 1, K_CLIP, 5, 3);
    tbl[15] = mv(160, 119, 1, K_CLIP, 6, 3);

    in_if.x = '0; in_if.y = '0; in_if.colour = '0; in_if.plot = 1'b0;
    out_if.ready = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_out_plot", 32'(out_if.plot), 32'd0);
    chk("rst_in_ready", 32'(in_if.ready), 32'd1);
    chk("rst_out_done", 32'(out_done), 32'd0);
    chk("rst_clip", 32'(clip_count), 32'd0);
    chk("rst_dup", 32'(dup_count), 32'd0);
    rst = 1'b0;
    out_if.ready = 1'b1;
    tick();

    // Single pixel latency: visible the cycle after acceptance, gone after pop
    send(mk(80, 60, 2), K_PUSH);
    chk("lat_plot", 32'(out_if.plot), 32'd1);
    chk("lat_x", 32'(out_if.x), 32'd80);
    chk("lat_y", 32'(out_if.y), 32'd60);
    chk("lat_colour", 32'(out_if.colour), 32'd2);
    tick();
    chk("lat_empty", 32'(out_if.plot), 32'd0);

    // Classification table
    pops0 = n_pop;
    npush = 0;
    foreach (tbl[i]) begin
      send(tbl[i].pix, tbl[i].kind);
      if (tbl[i].kind == K_PUSH) npush++;
      chk($sformatf("vec%0d_clip", i), 32'(clip_count), 32'(tbl[i].exp_clip));
      chk($sformatf("vec%0d_dup", i), 32'(dup_count), 32'(tbl[i].exp_dup));
    end
    wait_drain();
    chk("vec_pop_count", 32'(n_pop - pops0), 32'(npush));

    // Fill to full with the adapter stalled
    out_if.ready = 1'b0;
    pops0 = n_pop;
    for (int i = 0; i < DEPTH; i++) send(mk(i + 10, i + 5, i % 8), K_PUSH);
    chk("full_in_ready", 32'(in_if.ready), 32'd0);
    chk("full_out_plot", 32'(out_if.plot), 32'd1);
    clip0 = clip_count;
    in_if.x = 8'd200; in_if.y = 7'd0; in_if.colour = 3'd1; in_if.plot = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_hold_ready", 32'(in_if.ready), 32'd0);
    end
    tick();
    in_if.plot = 1'b0;
    chk("full_ignored_clip", 32'(clip_count), 32'(clip0));
    fork
      send(mk(50, 50, 6), K_PUSH);
      begin
        repeat (2) tick();
        out_if.ready = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
          @(negedge clk);
          if (j == 0) chk("full_no_passthru", 32'(in_if.ready), 32'd0);
          chk("drain_per_cycle", 32'(out_if.plot), 32'd1);
        end
      end
    join
    wait_drain();
    chk("full_pop_count", 32'(n_pop - pops0), 32'(DEPTH + 1));

    // Done held until the buffer drains
    out_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) send(mk(30 + i, 70, 1), K_PUSH);
    in_done = 1'b1;
    repeat (4) tick();
    chk("done_wait_data", 32'(out_done), 32'd0);
    out_if.ready = 1'b1;
    repeat (5) @(negedge clk);
    @(negedge clk);
    chk("done_not_early", 32'(out_done), 32'd0);
    @(negedge clk);
    chk("done_after_drain", 32'(out_done), 32'd1);
    @(posedge clk);
    #1 in_done = 1'b0;
    @(negedge clk);
    chk("done_held", 32'(out_done), 32'd1);
    @(negedge clk);
    chk("done_clear", 32'(out_done), 32'd0);
    tick();
    // Tracked pixel was forgotten when draining began, so a repeat is not a duplicate
    send(mk(34, 70, 1), K_PUSH);
    wait_drain();

    // Reset mid-drain discards everything
    out_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(60 + i, 10, 4), K_PUSH);
    in_done = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    in_done = 1'b0;
    sb.delete();
    repeat (2) tick();
    rst = 1'b0;
    out_if.ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("rstdrain_done", 32'(out_done), 32'd0);
      chk("rstdrain_plot", 32'(out_if.plot), 32'd0);
    end
    chk("rstdrain_clip", 32'(clip_count), 32'd0);
    chk("rstdrain_dup", 32'(dup_count), 32'd0);
    tick();

    // Circle r=40 at (80,60), midpoint algorithm, adapter randomly stalling
    ox = 40; oy = 0; crit = 1 - 40;
    while (oy <= ox) begin
      pts.push_back('{80 + ox, 60 + oy}); pts.push_back('{80 + oy, 60 + ox});
      pts.push_back('{80 - ox, 60 + oy}); pts.push_back('{80 - oy, 60 + ox});
      pts.push_back('{80 - ox, 60 - oy}); pts.push_back('{80 - oy, 60 - ox});
      pts.push_back('{80 + ox, 60 - oy}); pts.push_back('{80 + oy, 60 - ox});
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end
    m_lv = 1'b0; m_clip = 0; m_dup = 0; gen_done = 1'b0;
    got.delete();
    collect = 1'b1;
    fork
      begin
        foreach (pts[i]) begin
          p = mk(pts[i].x, pts[i].y, 4);
          if (pts[i].x >= 160 || pts[i].y >= 120) begin
            k = K_CLIP; m_clip++;
          end else if (m_lv && p == m_last) begin
            k = K_DUP; m_dup++;
          end else begin
            k = K_PUSH; m_last = p; m_lv = 1'b1;
            ref_set[int'({p.x, p.y})] = 1'b1;
          end
          send(p, k);
        end
        gen_done = 1'b1;
      end
      begin
        while (!gen_done) begin
          @(posedge clk);
          #1 out_if.ready = 1'($urandom_range(0, 1));
        end
        out_if.ready = 1'b1;
      end
    join
    wait_drain();
    collect = 1'b0;
    missing = 0;
    offscr = 0;
    foreach (ref_set[key]) if (!got.exists(key)) missing++;
    foreach (got[key]) if ((key >> 7) >= 160 || (key & 127) >= 120) offscr++;
    chk("circle_set_size", 32'(got.size()), 32'(ref_set.size()));
    chk("circle_missing", 32'(missing), 32'd0);
    chk("circle_offscreen", 32'(offscr), 32'd0);
    chk("circle_clip", 32'(clip_count), 32'(m_clip));
    chk("circle_dup", 32'(dup_count), 32'(m_dup));

    in_done = 1'b1;
    rises = 0;
    prev_done = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (out_done && !prev_done) rises++;
      prev_done = out_done;
    end
    chk("circle_done_once", 32'(rises), 32'd1);
    tick();
    in_done = 1'b0;
    repeat (2) tick();
    chk("circle_done_clear", 32'(out_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
